regbank_wr_fifo: RTL and testbench
==================================

// Module: regbank_wr_fifo
// PURPOSE
//  - Write-back staging between PE-tree result outputs and register_banks write port.
//  - One small FIFO per bank absorbs results produced while pipe_en is low or during bursts.
//  - Drains one word per bank per enabled cycle into register_banks.inputs / reg_we.
//  - Raises a global stall before any bank can overflow.
// PARAMETERS
//  NB         N_BANKS  number of register banks (from common_pkg)
//  DEPTH      4        entries per bank FIFO (power of 2, >=2)
//  AF_MARGIN  1        stall asserts when any count >= DEPTH-AF_MARGIN
// PORTS
//  clk      in   1           clock
//  rst      in   1           async reset, active-high
//  pipe_en  in   1           global pipeline enable; pop only when high
//  in_vld   in   NB          per-bank push request from PE outputs
//  in_data  in   NB x word_t per-bank result word
//  ovf_clr  in   1           clears all sticky overflow flags
//  out_we   out  NB          per-bank write request -> register_banks.reg_we
//  out_data out  NB x word_t per-bank head word -> register_banks.inputs
//  full     out  NB          count == DEPTH
//  stall    out  1           OR over banks of (count >= DEPTH-AF_MARGIN)
//  ovf      out  NB          sticky: push dropped because bank was full
// BEHAVIOUR
//  - Reset: count=0, rd/wr ptrs=0, out_we=0, out_data=0, full=0, stall=0, ovf=0; storage not cleared.
//  - Push(b) = in_vld[b], accepted when count<DEPTH or pop(b) same cycle.
//  - Pop(b)  = out_we[b] & pipe_en; out_we[b] = (count[b]!=0); out_data[b] = mem[rd_ptr] (0 when empty).
//  - Latency: word pushed in cycle t visible on out_data/out_we at t+1; FIFO order per bank.
//  - Push+pop same cycle: count unchanged, both ptrs advance; legal even at full (no ovf).
//  - Push at full without pop: word dropped, count unchanged, ovf[b] <= 1 next cycle.
//  - ovf_clr and a new overflow in same cycle: overflow wins (ovf stays 1).
//  - Pointers are log2(DEPTH) bits, wrap naturally; count is log2(DEPTH+1) bits, saturates at DEPTH.
//  - pipe_en=0: no pops; pushes still accepted (upstream honours stall).
//  - full/stall derived combinationally from registered count.
//  - Banks fully independent; no cross-bank ordering.
//  - Reset mid-operation: all queued words discarded, outputs to reset values asynchronously.
// CONFIGURATION
//  - REGBANK_WR_FIFO_BYPASS_EN defined: when count[b]==0 and in_vld[b], out_we[b]=1 and
//    out_data[b]=in_data[b] same cycle; if pipe_en=1 word not stored, else stored normally.
//  - Undefined: no combinational path in_* -> out_*; latency always 1 cycle.
// STRUCTURE
//  - common_pkg: word_t, N_BANKS, BIT_L (existing); add WR_FIFO_DEPTH, WR_FIFO_AF_MARGIN.
//  - common_pkg: typedef wr_fifo_ptr_t [$clog2(DEPTH)-1:0], wr_fifo_cnt_t [$clog2(DEPTH+1)-1:0].
//  - Sub-module regbank_wr_fifo_bank: single-bank FIFO (push, pop, data, count, ovf),
//    generated NB times; top does stall OR-reduction and ovf_clr fan-out.
//  - Assertions: count<=DEPTH; no pop when empty; in_vld while stall flagged as warning.
// TESTING
//  - Reset: assert rst with in_vld=all ones -> out_we=0, out_data=0, stall=0, ovf=0.
//  - Single push: pipe_en=1, in_vld[0]=1, data 16'h1234 at t -> out_we[0]=1, out_data[0]=16'h1234 at t+1, empty at t+2.
//  - Fill: pipe_en=0, push 16'hA0..16'hA3 bank 1 -> stall=1 after 3rd, full=1 after 4th; 5th push 16'hA4 dropped, ovf[1]=1.
//  - Drain: then pipe_en=1 -> out_data[1] = A0,A1,A2,A3 on 4 consecutive cycles; ovf stays 1 until ovf_clr.
//  - Full push+pop: bank 2 full, pipe_en=1, push 16'hBEEF -> count stays 4, ovf[2]=0, BEEF emerges 4th.
//  - Wrap: 10 alternating push/pop on bank 3 (data 0..9) -> output 0..9 in order, ptr wrap clean.
//  - Reset mid-drain: rst with 3 queued words -> out_we=0 at once; no stale word after release.
//  - Bypass (macro on): empty bank 0, pipe_en=1, push 16'h5555 -> out_we[0]=1 same cycle, count stays 0.

Source files
------------

// File: rtl/regbank_wr_fifo_pkg.sv
// Shared types and sizing for the register-bank write-back staging FIFOs.
package regbank_wr_fifo_pkg;

  localparam int BIT_L             = 16;
  localparam int N_BANKS           = 4;
  localparam int WR_FIFO_DEPTH     = 4;
  localparam int WR_FIFO_AF_MARGIN = 1;

  typedef logic [BIT_L-1:0]                       word_t;
  typedef logic [$clog2(WR_FIFO_DEPTH)-1:0]       wr_fifo_ptr_t;
  typedef logic [$clog2(WR_FIFO_DEPTH+1)-1:0]     wr_fifo_cnt_t;

endpackage

// File: rtl/regbank_wr_fifo_if.sv
// Handshake bundle between PE-tree results (master) and the write-back FIFO block (slave).
import regbank_wr_fifo_pkg::*;

interface regbank_wr_fifo_if;
  logic                pipe_en;
  logic                ovf_clr;
  logic [N_BANKS-1:0]  in_vld;
  word_t [N_BANKS-1:0] in_data;
  logic [N_BANKS-1:0]  out_we;
  word_t [N_BANKS-1:0] out_data;
  logic [N_BANKS-1:0]  full;
  logic                stall;
  logic [N_BANKS-1:0]  ovf;

  modport master (
    output pipe_en, ovf_clr, in_vld, in_data,
    input  out_we, out_data, full, stall, ovf
  );

  modport slave (
    input  pipe_en, ovf_clr, in_vld, in_data,
    output out_we, out_data, full, stall, ovf
  );
endinterface

// File: rtl/regbank_wr_fifo_bank.sv
// Single-bank write-back FIFO: push, pop on enable, head word out, sticky overflow.
// Optional REGBANK_WR_FIFO_BYPASS_EN forwards a push straight to the output when the bank is empty.
import regbank_wr_fifo_pkg::*;

module regbank_wr_fifo_bank #(
  parameter int DEPTH = WR_FIFO_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  word_t                        data_i,
  input  logic                         pop_en_i,
  input  logic                         ovf_clr_i,
  output logic                         we_o,
  output word_t                        data_o,
  output logic [$clog2(DEPTH+1)-1:0]   cnt_o,
  output logic                         full_o,
  output logic                         ovf_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  word_t           mem_q [DEPTH];
  logic [PW-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            head_vld, pop, store, accept, drop;

  always_comb begin
    head_vld = (cnt_q != '0);
    pop      = head_vld & pop_en_i;
`ifdef REGBANK_WR_FIFO_BYPASS_EN
    // An empty bank forwards the push; it is only queued if nothing consumes it this cycle.
    store    = push_i & ~(~head_vld & pop_en_i);
    we_o     = head_vld | push_i;
    data_o   = head_vld ? mem_q[rd_q] : (push_i ? data_i : '0);
`else
    store    = push_i;
    we_o     = head_vld;
    data_o   = head_vld ? mem_q[rd_q] : '0;
`endif
    accept   = store & ((cnt_q != FULL_CNT) | pop);
    drop     = store & ~accept;
    rd_d     = pop    ? rd_q + PW'(1) : rd_q;
    wr_d     = accept ? wr_q + PW'(1) : wr_q;
    cnt_d    = cnt_q;
    if (accept && !pop)      cnt_d = cnt_q + CW'(1);
    else if (pop && !accept) cnt_d = cnt_q - CW'(1);
    // A fresh overflow outranks a simultaneous clear.
    ovf_d    = drop | (ovf_q & ~ovf_clr_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_q] <= data_i;
  end

  assign cnt_o  = cnt_q;
  assign full_o = (cnt_q == FULL_CNT);
  assign ovf_o  = ovf_q;

`ifndef SYNTHESIS
  a_cnt_range: assert property (@(posedge clk) disable iff (rst) cnt_q <= FULL_CNT);
  a_no_empty_pop: assert property (@(posedge clk) disable iff (rst) pop |-> head_vld);
`endif

endmodule

// File: rtl/regbank_wr_fifo.sv
// Write-back staging: one FIFO per register bank, drained one word per bank per enabled cycle.
// Build option REGBANK_WR_FIFO_BYPASS_EN enables same-cycle forwarding into empty banks.
import regbank_wr_fifo_pkg::*;

module regbank_wr_fifo #(
  parameter int AF_MARGIN = WR_FIFO_AF_MARGIN
) (
  input  logic                clk,
  input  logic                rst,
  regbank_wr_fifo_if.slave    bus
);

  localparam int CW = $clog2(WR_FIFO_DEPTH+1);
  localparam logic [CW-1:0] AF_LVL = CW'(WR_FIFO_DEPTH - AF_MARGIN);

  wr_fifo_cnt_t        cnt_w [N_BANKS];
  logic [N_BANKS-1:0]  we_w, full_w, ovf_w, af_w;
  word_t [N_BANKS-1:0] data_w;

  for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
    regbank_wr_fifo_bank #(.DEPTH(WR_FIFO_DEPTH)) u_bank (
      .clk       (clk),
      .rst       (rst),
      .push_i    (bus.in_vld[b]),
      .data_i    (bus.in_data[b]),
      .pop_en_i  (bus.pipe_en),
      .ovf_clr_i (bus.ovf_clr),
      .we_o      (we_w[b]),
      .data_o    (data_w[b]),
      .cnt_o     (cnt_w[b]),
      .full_o    (full_w[b]),
      .ovf_o     (ovf_w[b])
    );
    assign af_w[b] = (cnt_w[b] >= AF_LVL);
  end

  assign bus.out_we   = we_w;
  assign bus.out_data = data_w;
  assign bus.full     = full_w;
  assign bus.ovf      = ovf_w;
  assign bus.stall    = |af_w;

`ifndef SYNTHESIS
  a_push_under_stall: assert property (@(posedge clk) disable iff (rst) !(bus.stall && (|bus.in_vld)))
    else $warning("in_vld asserted while stall is high");
`endif

endmodule

// File: tb/tb_regbank_wr_fifo.sv
// Directed bench for regbank_wr_fifo: reset, latency, fill/overflow, drain, push+pop at full, wrap, mid-run reset.
import regbank_wr_fifo_pkg::*;

module tb_regbank_wr_fifo;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;

  regbank_wr_fifo_if bus ();

  regbank_wr_fifo u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int b, input word_t d);
    bus.in_vld        = '0;
    bus.in_vld[b]     = 1'b1;
    bus.in_data[b]    = d;
    step();
    bus.in_vld        = '0;
  endtask

  initial begin
    rst         = 1'b1;
    bus.pipe_en = 1'b0;
    bus.ovf_clr = 1'b0;
    bus.in_vld  = '1;
    bus.in_data = '0;
    step();
    step();
    chk("rst_out_we",   32'(bus.out_we),   32'h0);
    chk("rst_out_data", 32'(bus.out_data), 32'h0);
    chk("rst_stall",    32'(bus.stall),    32'h0);
    chk("rst_ovf",      32'(bus.ovf),      32'h0);
    chk("rst_full",     32'(bus.full),     32'h0);
    bus.in_vld = '0;
    rst        = 1'b0;
    step();

    // single push, one-cycle latency, then empty
    bus.pipe_en = 1'b1;
    push(0, 16'h1234);
    chk("single_we",   32'(bus.out_we[0]),   32'h1);
    chk("single_data", 32'(bus.out_data[0]), 32'h1234);
    step();
    chk("single_empty_we",   32'(bus.out_we[0]),   32'h0);
    chk("single_empty_data", 32'(bus.out_data[0]), 32'h0);

    // fill bank 1 with pops disabled
    bus.pipe_en = 1'b0;
    push(1, 16'hA0);
    push(1, 16'hA1);
    chk("fill2_stall", 32'(bus.stall), 32'h0);
    push(1, 16'hA2);
    chk("fill3_stall", 32'(bus.stall), 32'h1);
    chk("fill3_full",  32'(bus.full[1]), 32'h0);
    push(1, 16'hA3);
    chk("fill4_full",  32'(bus.full[1]), 32'h1);
    chk("fill4_ovf",   32'(bus.ovf[1]),  32'h0);
    push(1, 16'hA4);
    chk("fill5_ovf",   32'(bus.ovf[1]),  32'h1);
    chk("fill5_full",  32'(bus.full[1]), 32'h1);
    chk("fill5_head",  32'(bus.out_data[1]), 32'hA0);

    // drain in order; ovf remains sticky
    bus.pipe_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_we",   32'(bus.out_we[1]),   32'h1);
      chk("drain_data", 32'(bus.out_data[1]), 32'(16'hA0 + i));
      step();
    end
    chk("drain_empty", 32'(bus.out_we[1]), 32'h0);
    chk("drain_stall", 32'(bus.stall),     32'h0);
    chk("ovf_sticky",  32'(bus.ovf[1]),    32'h1);
    bus.ovf_clr = 1'b1;
    step();
    bus.ovf_clr = 1'b0;
    chk("ovf_cleared", 32'(bus.ovf[1]), 32'h0);

    // push + pop on a full bank
    bus.pipe_en = 1'b0;
    for (int i = 0; i < 4; i++) push(2, word_t'(16'hC0 + i));
    chk("pp_full_before", 32'(bus.full[2]), 32'h1);
    bus.pipe_en = 1'b1;
    push(2, 16'hBEEF);
    chk("pp_full_after", 32'(bus.full[2]), 32'h1);
    chk("pp_no_ovf",     32'(bus.ovf[2]),  32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("pp_data", 32'(bus.out_data[2]), 32'(16'hC1 + i));
      step();
    end
    chk("pp_beef", 32'(bus.out_data[2]), 32'hBEEF);
    step();
    chk("pp_empty", 32'(bus.out_we[2]), 32'h0);

    // alternating push/pop walks pointers around several times
    for (int i = 0; i < 10; i++) begin
      push(3, word_t'(i));
      chk("wrap_data", 32'(bus.out_data[3]), 32'(i));
      step();
      chk("wrap_empty", 32'(bus.out_we[3]), 32'h0);
    end

    // reset with words queued
    bus.pipe_en = 1'b0;
    push(0, 16'hD0);
    push(0, 16'hD1);
    push(0, 16'hD2);
    chk("mid_queued", 32'(bus.out_we[0]), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_we",   32'(bus.out_we),   32'h0);
    chk("mid_rst_data", 32'(bus.out_data), 32'h0);
    chk("mid_rst_full", 32'(bus.full),     32'h0);
    step();
    rst = 1'b0;
    bus.pipe_en = 1'b1;
    step();
    chk("mid_post_we",   32'(bus.out_we),   32'h0);
    chk("mid_post_data", 32'(bus.out_data), 32'h0);

`ifdef REGBANK_WR_FIFO_BYPASS_EN
    bus.in_vld      = 4'b0001;
    bus.in_data[0]  = 16'h5555;
    #1;
    chk("byp_we",   32'(bus.out_we[0]),   32'h1);
    chk("byp_data", 32'(bus.out_data[0]), 32'h5555);
    step();
    bus.in_vld = '0;
    #1;
    chk("byp_not_stored", 32'(bus.out_we[0]), 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, want finish");
    $fatal(1, "timeout");
  end

endmodule
